// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encoding,
// register-index width and the load-use detection helper.
package hazard_controller_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    S_RUN      = 2'b00,
    S_MEM_WAIT = 2'b01,
    S_FAULT    = 2'b10
  } hz_state_e;

  // A load in EX feeds a register the ID instruction reads; x0 never hazards.
  function automatic logic f_load_use(
    input logic                 mem_read,
    input logic [REG_IDX_W-1:0] ex_rd,
    input logic [REG_IDX_W-1:0] rs1,
    input logic                 use_rs1,
    input logic [REG_IDX_W-1:0] rs2,
    input logic                 use_rs2
  );
    logic w_rd_live;
    w_rd_live  = mem_read && (ex_rd != {REG_IDX_W{1'b0}});
    f_load_use = w_rd_live && ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
  endfunction

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating event counter with synchronous clear that wins over increment.
module hazard_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear first, then increment until all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_controller.sv
// In-order pipeline hazard controller: memory freeze with timeout fault,
// branch flush, single-cycle load-use stall, and performance counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [REG_IDX_W-1:0] i_id_rs1,
  input  logic [REG_IDX_W-1:0] i_id_rs2,
  input  logic                 i_id_use_rs1,
  input  logic                 i_id_use_rs2,
  input  logic [REG_IDX_W-1:0] i_ex_rd,
  input  logic                 i_ex_mem_read,
  input  logic                 i_ex_branch_taken,
  input  logic                 i_dmem_req,
  input  logic                 i_dmem_ready,
  input  logic                 i_cnt_clr,
  output logic                 o_pc_en,
  output logic                 o_ifid_en,
  output logic                 o_idex_en,
  output logic                 o_exmem_en,
  output logic                 o_ifid_flush,
  output logic                 o_idex_flush,
  output logic                 o_memwb_bubble,
  output logic                 o_fault,
  output logic [CNT_W-1:0]     o_stall_cnt,
  output logic [CNT_W-1:0]     o_flush_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hz_state_e         r_state;
  hz_state_e         w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_lu_done;
  logic              w_lu_done_nxt;
  logic              w_freeze;
  logic              w_lu_hit;
  logic [6:0]        w_ctl;

  assign w_freeze = i_dmem_req && !i_dmem_ready;
  assign w_lu_hit = f_load_use(i_ex_mem_read, i_ex_rd, i_id_rs1, i_id_use_rs1,
                               i_id_rs2, i_id_use_rs2);

  // State, wait counter and the flag that limits a load-use stall to one cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_RUN;
      r_wait_cnt <= {WAIT_W{1'b0}};
      r_lu_done  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_lu_done  <= w_lu_done_nxt;
    end
  end

  // Next state and control vector {pc,ifid,idex,exmem,ifid_fl,idex_fl,bubble}.
  always_comb begin
    w_state_nxt   = r_state;
    w_wait_nxt    = r_wait_cnt;
    w_lu_done_nxt = 1'b0;
    w_ctl         = 7'b1111_000;
    case (r_state)
      S_FAULT: begin
        w_ctl = 7'b0000_001;
      end
      S_RUN, S_MEM_WAIT: begin
        if (w_freeze) begin
          w_ctl = 7'b0000_001;
          if (r_state == S_RUN) begin
            w_state_nxt = S_MEM_WAIT;
            w_wait_nxt  = WAIT_ONE;
          end else if (r_wait_cnt >= WAIT_MAX) begin
            w_state_nxt = S_FAULT;
          end else begin
            w_wait_nxt = r_wait_cnt + WAIT_ONE;
          end
        end else begin
          w_state_nxt = S_RUN;
          w_wait_nxt  = {WAIT_W{1'b0}};
          if (i_ex_branch_taken) begin
            w_ctl = 7'b1111_110;
          end else if (w_lu_hit && !r_lu_done) begin
            w_ctl         = 7'b0011_010;
            w_lu_done_nxt = 1'b1;
          end else begin
            w_ctl = 7'b1111_000;
          end
        end
      end
      default: begin
        w_state_nxt = S_FAULT;
        w_ctl       = 7'b0000_001;
      end
    endcase
  end

  // Everything is held quiet while reset is asserted.
  assign {o_pc_en, o_ifid_en, o_idex_en, o_exmem_en,
          o_ifid_flush, o_idex_flush, o_memwb_bubble} = i_rst_n ? w_ctl : 7'b0000_000;
  assign o_fault = (r_state == S_FAULT);

  hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (!w_ctl[6]),
    .o_cnt   (o_stall_cnt)
  );

  hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_cnt_clr),
    .i_inc   (w_ctl[2]),
    .o_cnt   (o_flush_cnt)
  );

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a vector table for single-cycle
// behaviour plus sequences for memory wait, timeout fault and saturation.
module tb_hazard_controller;

  localparam logic [6:0] CTL_RUN = 7'b1111_000;
  localparam logic [6:0] CTL_LU  = 7'b0011_010;
  localparam logic [6:0] CTL_BR  = 7'b1111_110;
  localparam logic [6:0] CTL_FRZ = 7'b0000_001;
  localparam logic [6:0] CTL_OFF = 7'b0000_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [4:0] rs1, rs2, rd;
  logic use1, use2, mrd, br, req, rdy, clr;

  logic pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, bubble, fault;
  logic [15:0] stall_cnt, flush_cnt;
  logic pc4, ifid4, idex4, exmem4, ifidf4, idexf4, bub4, fault4;
  logic [3:0] stall4, flush4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_controller #(.MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_rd(rd), .i_ex_mem_read(mrd),
    .i_ex_branch_taken(br), .i_dmem_req(req), .i_dmem_ready(rdy), .i_cnt_clr(clr),
    .o_pc_en(pc_en), .o_ifid_en(ifid_en), .o_idex_en(idex_en), .o_exmem_en(exmem_en),
    .o_ifid_flush(ifid_fl), .o_idex_flush(idex_fl), .o_memwb_bubble(bubble),
    .o_fault(fault), .o_stall_cnt(stall_cnt), .o_flush_cnt(flush_cnt)
  );

  hazard_controller #(.MEM_TIMEOUT(15), .CNT_W(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_id_rs1(rs1), .i_id_rs2(rs2),
    .i_id_use_rs1(use1), .i_id_use_rs2(use2), .i_ex_rd(rd), .i_ex_mem_read(mrd),
    .i_ex_branch_taken(br), .i_dmem_req(req), .i_dmem_ready(rdy), .i_cnt_clr(clr),
    .o_pc_en(pc4), .o_ifid_en(ifid4), .o_idex_en(idex4), .o_exmem_en(exmem4),
    .o_ifid_flush(ifidf4), .o_idex_flush(idexf4), .o_memwb_bubble(bub4),
    .o_fault(fault4), .o_stall_cnt(stall4), .o_flush_cnt(flush4)
  );

  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic        use1, use2, mrd, br, req, rdy;
    logic [6:0]  ctl;
    logic [15:0] stall, flush;
  } vec_t;

  vec_t vt[18];

  function automatic logic [6:0] ctl_now();
    return {pc_en, ifid_en, idex_en, exmem_en, ifid_fl, idex_fl, bubble};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    use1 = 1'b0; use2 = 1'b0; mrd = 1'b0; br = 1'b0;
    req = 1'b0; rdy = 1'b0; clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("reset_ctl", 32'(ctl_now()), 32'(CTL_OFF));
    chk("reset_fault", 32'(fault), 32'd0);
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // rs1 rs2 rd u1 u2 mrd br req rdy ctl stall flush
    vt[0]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd0, 16'd0};
    vt[1]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CTL_LU,  16'd1, 16'd0};
    vt[2]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd1, 16'd0};
    vt[3]  = '{5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd1, 16'd0};
    vt[4]  = '{5'd0, 5'd7, 5'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, CTL_LU,  16'd2, 16'd0};
    vt[5]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd2, 16'd0};
    vt[6]  = '{5'd9, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd2, 16'd0};
    vt[7]  = '{5'd9, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd2, 16'd0};
    vt[8]  = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, CTL_BR,  16'd2, 16'd1};
    vt[9]  = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, CTL_BR,  16'd2, 16'd2};
    vt[10] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, CTL_FRZ, 16'd3, 16'd2};
    vt[11] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, CTL_BR,  16'd3, 16'd3};
    vt[12] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, CTL_RUN, 16'd3, 16'd3};
    vt[13] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, CTL_FRZ, 16'd4, 16'd3};
    vt[14] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, CTL_LU,  16'd5, 16'd3};
    vt[15] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd5, 16'd3};
    vt[16] = '{5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, CTL_RUN, 16'd5, 16'd3};
    vt[17] = '{5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, CTL_LU,  16'd6, 16'd3};

    idle_inputs();
    do_reset();

    for (int i = 0; i < 18; i++) begin
      rs1 = vt[i].rs1; rs2 = vt[i].rs2; rd = vt[i].rd;
      use1 = vt[i].use1; use2 = vt[i].use2; mrd = vt[i].mrd; br = vt[i].br;
      req = vt[i].req; rdy = vt[i].rdy;
      #1;
      chk($sformatf("vec%0d_ctl", i), 32'(ctl_now()), 32'(vt[i].ctl));
      tick();
      chk($sformatf("vec%0d_stall", i), 32'(stall_cnt), 32'(vt[i].stall));
      chk($sformatf("vec%0d_flush", i), 32'(flush_cnt), 32'(vt[i].flush));
    end

    // Three frozen cycles then ready: back to run rules on the ready cycle.
    do_reset();
    req = 1'b1; rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("wait%0d_ctl", i), 32'(ctl_now()), 32'(CTL_FRZ));
      tick();
    end
    rdy = 1'b1;
    #1;
    chk("wait_ready_ctl", 32'(ctl_now()), 32'(CTL_RUN));
    tick();
    chk("wait_stall", 32'(stall_cnt), 32'd3);
    chk("wait_nofault", 32'(fault), 32'd0);

    // Reset landing in the middle of a memory wait.
    rdy = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midwait_rst_ctl", 32'(ctl_now()), 32'(CTL_OFF));
    chk("midwait_rst_stall", 32'(stall_cnt), 32'd0);
    idle_inputs();
    tick();
    rst_n = 1'b1;
    #1;
    chk("midwait_post_ctl", 32'(ctl_now()), 32'(CTL_RUN));

    // Memory never ready: fault after 16 freeze cycles, counters saturate.
    do_reset();
    req = 1'b1; rdy = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("timeout_pre_fault", 32'(fault), 32'd0);
    end
    chk("timeout_fault", 32'(fault), 32'd1);
    req = 1'b0;
    #1;
    chk("fault_ctl", 32'(ctl_now()), 32'(CTL_FRZ));
    for (int i = 17; i <= 20; i++) tick();
    chk("fault_sticky", 32'(fault), 32'd1);
    chk("stall20_w16", 32'(stall_cnt), 32'd20);
    chk("stall20_w4_sat", 32'(stall4), 32'd15);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_w16", 32'(stall_cnt), 32'd0);
    chk("clr_w4", 32'(stall4), 32'd0);
    tick();
    chk("fault_still", 32'(fault), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("fault_rst_fault", 32'(fault), 32'd0);
    chk("fault_rst_ctl", 32'(ctl_now()), 32'(CTL_OFF));
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_fault_ctl", 32'(ctl_now()), 32'(CTL_RUN));
    tick();
    chk("post_fault_stall", 32'(stall_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
